// File: rtl/tinker_prog_loader_pkg.sv
// Shared types and constants for the Tinker program loader.
// The loader state enum plus the memory map values the core also relies on.
package tinker_prog_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_DATA,
      ST_DONE,
      ST_ERR
   } loader_state_t;

   localparam logic [63:0] TINKER_RESET_PC  = 64'h2000;
   localparam int unsigned TINKER_MEM_BYTES = 524288;
   localparam logic [31:0] TINKER_MAX_WORDS = 32'd4096;

   // Byte address of doubleword k, counted from an 8-byte aligned base.
   function automatic logic [63:0] dwAddr(input logic [63:0] base, input logic [31:0] k);
      return base + {29'd0, k, 3'b000};
   endfunction

endpackage

// File: rtl/tinker_prog_loader_if.sv
// Byte-stream input and memory write port of the program loader.
// The master view belongs to the loader; the slave view to the stream source and memory.
interface tinker_prog_loader_if;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_wr_en;
   logic [63:0] mem_addr;
   logic [63:0] mem_wr_data;

   modport master (
      input  in_valid, in_data,
      output in_ready, mem_wr_en, mem_addr, mem_wr_data
   );

   modport slave (
      output in_valid, in_data,
      input  in_ready, mem_wr_en, mem_addr, mem_wr_data
   );
endinterface

// File: rtl/tinker_prog_loader_packer.sv
// Little-endian byte packer: places bytes at an index into a doubleword and
// emits a registered write when full or when told the current byte is the last.
module tinker_byte_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_clear,
   input  logic        i_valid,
   input  logic [7:0]  i_data,
   input  logic        i_last,
   output logic        o_flush,
   output logic [1:0]  o_flushWords,
   output logic        o_wrEn,
   output logic [63:0] o_wrData
);

   logic [63:0] r_buf;
   logic [2:0]  r_idx;
   logic        r_wrEn;
   logic [63:0] r_wrData;
   logic [63:0] w_merged;

   always_comb begin
      w_merged = r_buf;
      w_merged[{r_idx, 3'b000} +: 8] = i_data;
   end

   assign o_flush      = i_valid & ((r_idx == 3'd7) | i_last);
   assign o_flushWords = (r_idx == 3'd7) ? 2'd2 : 2'd1;

   // Buffer is zeroed after each flush so a short final write is zero padded.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_buf    <= '0;
         r_idx    <= '0;
         r_wrEn   <= 1'b0;
         r_wrData <= '0;
      end else begin
         r_wrEn <= o_flush;
         if (i_clear) begin
            r_buf <= '0;
            r_idx <= '0;
         end else if (i_valid) begin
            if (o_flush) begin
               r_wrData <= w_merged;
               r_buf    <= '0;
               r_idx    <= '0;
            end else begin
               r_buf <= w_merged;
               r_idx <= r_idx + 3'd1;
            end
         end
      end
   end

   assign o_wrEn   = r_wrEn;
   assign o_wrData = r_wrData;

endmodule

// File: rtl/tinker_prog_loader.sv
// Program loader: takes a length-prefixed LE byte stream, writes 64-bit words
// from BASE_ADDR upward, and holds the core in reset until the image is in.
module tinker_prog_loader
   import tinker_prog_loader_pkg::*;
#(
   parameter logic [63:0] BASE_ADDR = TINKER_RESET_PC,
   parameter logic [31:0] MAX_WORDS = TINKER_MAX_WORDS
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        i_start,
   tinker_prog_loader_if.master        bus,
   output logic                        o_core_reset,
   output logic                        o_load_done,
   output logic                        o_error,
   output logic [31:0]                 o_words_loaded
);

   loader_state_t r_state, w_nextState;
   logic [1:0]  r_lenIdx;
   logic [23:0] r_len;
   logic [31:0] r_bytesLeft;
   logic        r_final;
   logic [31:0] r_dwCount;
   logic [63:0] r_memAddr;
   logic [31:0] r_wordsLoaded;
   logic        r_coreReset;

   logic        w_inReady;
   logic        w_start;
   logic        w_lenXfer;
   logic        w_dataXfer;
   logic        w_lastByte;
   logic [31:0] w_lenFull;
   logic        w_flush;
   logic [1:0]  w_flushWords;

   assign w_lenXfer  = bus.in_valid & w_inReady & (r_state == ST_LEN);
   assign w_dataXfer = bus.in_valid & w_inReady & (r_state == ST_DATA);
   assign w_lastByte = w_dataXfer & (r_bytesLeft == 32'd1);
   assign w_lenFull  = {bus.in_data, r_len};
   assign w_start    = i_start & ((r_state == ST_IDLE) | (r_state == ST_DONE) | (r_state == ST_ERR));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_nextState;
   end

   // Once the last byte is in, input is closed until the final write retires.
   always_comb begin
      w_nextState = r_state;
      w_inReady   = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (i_start) w_nextState = ST_LEN;
         end
         ST_LEN: begin
            w_inReady = 1'b1;
            if (w_lenXfer && r_lenIdx == 2'd3) begin
               if (w_lenFull == 32'd0)          w_nextState = ST_DONE;
               else if (w_lenFull > MAX_WORDS) w_nextState = ST_ERR;
               else                             w_nextState = ST_DATA;
            end
         end
         ST_DATA: begin
            w_inReady = ~r_final;
            if (r_final) w_nextState = ST_DONE;
         end
         default: w_nextState = ST_IDLE;
      endcase
   end

   tinker_byte_packer u_packer (
      .clk          (clk),
      .reset        (reset),
      .i_clear      (w_start),
      .i_valid      (w_dataXfer),
      .i_data       (bus.in_data),
      .i_last       (w_lastByte),
      .o_flush      (w_flush),
      .o_flushWords (w_flushWords),
      .o_wrEn       (bus.mem_wr_en),
      .o_wrData     (bus.mem_wr_data)
   );

   // Address and word count update on the flush edge so they appear with the strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lenIdx      <= '0;
         r_len         <= '0;
         r_bytesLeft   <= '0;
         r_final       <= 1'b0;
         r_dwCount     <= '0;
         r_memAddr     <= BASE_ADDR;
         r_wordsLoaded <= '0;
         r_coreReset   <= 1'b1;
      end else begin
         r_coreReset <= (w_nextState != ST_DONE);
         if (w_start) begin
            r_lenIdx      <= '0;
            r_len         <= '0;
            r_final       <= 1'b0;
            r_dwCount     <= '0;
            r_wordsLoaded <= '0;
         end
         if (w_lenXfer) begin
            r_len    <= w_lenFull[31:8];
            r_lenIdx <= r_lenIdx + 2'd1;
            if (r_lenIdx == 2'd3) r_bytesLeft <= {w_lenFull[29:0], 2'b00};
         end
         if (w_dataXfer) begin
            r_bytesLeft <= r_bytesLeft - 32'd1;
            if (w_lastByte) r_final <= 1'b1;
         end
         if (w_flush) begin
            r_memAddr     <= dwAddr(BASE_ADDR, r_dwCount);
            r_dwCount     <= r_dwCount + 32'd1;
            r_wordsLoaded <= r_wordsLoaded + {30'd0, w_flushWords};
         end
      end
   end

   assign bus.in_ready   = w_inReady;
   assign bus.mem_addr   = r_memAddr;
   assign o_core_reset   = r_coreReset;
   assign o_load_done    = (r_state == ST_DONE);
   assign o_error        = (r_state == ST_ERR);
   assign o_words_loaded = r_wordsLoaded;

endmodule

// File: tb/tb_tinker_prog_loader.sv
// Bench for tinker_prog_loader: a table of loads with fixed or random images,
// checked against a doubleword-level model, plus a mid-load reset sequence.
module tb_tinker_prog_loader;
   import tinker_prog_loader_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        core_reset;
   logic        load_done;
   logic        error;
   logic [31:0] words_loaded;

   tinker_prog_loader_if bus();

   tinker_prog_loader dut (
      .clk            (clk),
      .reset          (reset),
      .i_start        (start),
      .bus            (bus.master),
      .o_core_reset   (core_reset),
      .o_load_done    (load_done),
      .o_error        (error),
      .o_words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] addr;
      logic [63:0] data;
      logic [31:0] wl;
   } wr_t;

   typedef struct {
      int n;
      int kind;
      bit gaps;
      bit expErr;
   } vec_t;

   int checks = 0;
   int fails  = 0;

   wr_t         seen[$];
   logic [31:0] curWords[$];
   int          cycle       = 0;
   int          lastWrCycle = -1;
   int          fallCycle   = -1;
   logic        prevCr      = 1'b1;

   // Records every write strobe and the cycle core_reset drops.
   always @(negedge clk) begin
      cycle++;
      if (bus.mem_wr_en === 1'b1) begin
         seen.push_back('{bus.mem_addr, bus.mem_wr_data, words_loaded});
         lastWrCycle = cycle;
      end
      if (prevCr === 1'b1 && core_reset === 1'b0) fallCycle = cycle;
      prevCr = core_reset;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_in_ready"},    bus.in_ready,    1'b0);
      checkOutput({tag, "_mem_wr_en"},   bus.mem_wr_en,   1'b0);
      checkOutput({tag, "_mem_addr"},    bus.mem_addr,    64'h2000);
      checkOutput({tag, "_mem_wr_data"}, bus.mem_wr_data, 64'h0);
      checkOutput({tag, "_core_reset"},  core_reset,      1'b1);
      checkOutput({tag, "_load_done"},   load_done,       1'b0);
      checkOutput({tag, "_error"},       error,           1'b0);
      checkOutput({tag, "_words"},       words_loaded,    32'd0);
   endtask

   task automatic pulseStart();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Offers one byte and returns at the negedge after it has been taken.
   task automatic applyStimulus(input logic [7:0] b, input bit gaps);
      int t;
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            @(negedge clk);
         end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      for (t = 0; t < 50; t++) begin
         if (bus.in_ready === 1'b1) break;
         @(negedge clk);
      end
      if (t == 50) checkOutput("ready_timeout", bus.in_ready, 1'b1);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic runLoad(input int n, input bit gaps, input bit expErr, input string tag);
      logic [31:0] nl;
      wr_t         exp[$];
      int          t;
      nl = 32'(n);
      seen.delete();
      fallCycle   = -1;
      lastWrCycle = -1;
      pulseStart();
      checkOutput({tag, "_len_ready"}, bus.in_ready, 1'b1);
      checkOutput({tag, "_len_cr"},    core_reset,   1'b1);
      checkOutput({tag, "_len_err"},   error,        1'b0);
      checkOutput({tag, "_len_words"}, words_loaded, 32'd0);
      for (int i = 0; i < 4; i++) applyStimulus(nl[8*i +: 8], gaps);

      if (expErr) begin
         checkOutput({tag, "_err"},       error,        1'b1);
         checkOutput({tag, "_err_ready"}, bus.in_ready, 1'b0);
         checkOutput({tag, "_err_cr"},    core_reset,   1'b1);
         bus.in_valid = 1'b1;
         bus.in_data  = 8'hA5;
         repeat (3) @(negedge clk);
         bus.in_valid = 1'b0;
         checkOutput({tag, "_err_nowr"},  64'(seen.size()), 64'd0);
         checkOutput({tag, "_err_stick"}, error,            1'b1);
         return;
      end

      if (n == 0) begin
         checkOutput({tag, "_n0_done"}, load_done,        1'b1);
         checkOutput({tag, "_n0_cr"},   core_reset,       1'b0);
         @(negedge clk);
         checkOutput({tag, "_n0_nowr"}, 64'(seen.size()), 64'd0);
         return;
      end

      foreach (curWords[i])
         for (int b = 0; b < 4; b++) applyStimulus(curWords[i][8*b +: 8], gaps);

      for (t = 0; t < 20; t++) begin
         if (load_done === 1'b1) break;
         @(negedge clk);
      end
      if (t == 20) checkOutput({tag, "_done_timeout"}, load_done, 1'b1);
      @(negedge clk);

      // Reference: doubleword k holds words 2k and 2k+1, missing upper word is zero.
      for (int k = 0; 2*k < n; k++) begin
         wr_t e;
         e.addr = 64'h2000 + 64'(8*k);
         e.data = {(2*k+1 < n) ? curWords[2*k+1] : 32'h0, curWords[2*k]};
         e.wl   = 32'((2*k+2 < n) ? 2*k+2 : n);
         exp.push_back(e);
      end
      checkOutput({tag, "_wr_count"}, 64'(seen.size()), 64'(exp.size()));
      foreach (exp[k]) begin
         if (k < seen.size()) begin
            checkOutput($sformatf("%s_addr%0d", tag, k), seen[k].addr, exp[k].addr);
            checkOutput($sformatf("%s_data%0d", tag, k), seen[k].data, exp[k].data);
            checkOutput($sformatf("%s_wl%0d",   tag, k), seen[k].wl,   exp[k].wl);
         end
      end
      checkOutput({tag, "_words"},    words_loaded,     64'(n));
      checkOutput({tag, "_done"},     load_done,        1'b1);
      checkOutput({tag, "_cr"},       core_reset,       1'b0);
      checkOutput({tag, "_error"},    error,            1'b0);
      checkOutput({tag, "_cr_fall"},  64'(fallCycle),   64'(lastWrCycle + 1));
   endtask

   vec_t vecs[$];

   initial begin
      reset        = 1'b1;
      start        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      repeat (3) @(negedge clk);
      checkResetValues("rst");
      reset = 1'b0;
      @(negedge clk);
      checkOutput("idle_ready", bus.in_ready, 1'b0);

      vecs = '{
         '{2,    1, 1'b0, 1'b0},
         '{3,    2, 1'b0, 1'b0},
         '{0,    0, 1'b0, 1'b0},
         '{4097, 0, 1'b0, 1'b1},
         '{2,    0, 1'b0, 1'b0},
         '{4,    3, 1'b1, 1'b0},
         '{1,    0, 1'b1, 1'b0},
         '{5,    0, 1'b1, 1'b0},
         '{8,    0, 1'b0, 1'b0},
         '{4096, 0, 1'b0, 1'b0}
      };

      foreach (vecs[v]) begin
         curWords.delete();
         case (vecs[v].kind)
            1: curWords = '{32'h44332211, 32'h88776655};
            2: curWords = '{32'hC8000000, 32'h12345678, 32'hDEADBEEF};
            3: begin
               curWords = '{32'h01020304, 32'h05060708, 32'h01020304, 32'h05060708};
            end
            default: if (!vecs[v].expErr)
               for (int i = 0; i < vecs[v].n; i++) curWords.push_back($urandom);
         endcase
         runLoad(vecs[v].n, vecs[v].gaps, vecs[v].expErr, $sformatf("v%0d", v));
         if (vecs[v].kind == 1 && seen.size() > 0)
            checkOutput("t1_data", seen[0].data, 64'h8877665544332211);
         if (vecs[v].kind == 2 && seen.size() > 1)
            checkOutput("t2_data1", seen[1].data, 64'h00000000DEADBEEF);
         if (vecs[v].kind == 3 && seen.size() > 1)
            checkOutput("t5_same", seen[1].data, 64'h0506070801020304);
      end

      // Start while a load is in progress must be ignored.
      curWords = '{32'hCAFEF00D, 32'h0BADC0DE};
      seen.delete();
      pulseStart();
      applyStimulus(8'h02, 1'b0);
      pulseStart();
      checkOutput("start_ignored_ready", bus.in_ready, 1'b1);
      for (int i = 1; i < 4; i++) applyStimulus(8'h00, 1'b0);
      for (int b = 0; b < 8; b++) applyStimulus(b < 4 ? curWords[0][8*b +: 8] : curWords[1][8*(b-4) +: 8], 1'b0);
      repeat (3) @(negedge clk);
      checkOutput("start_ignored_done", load_done, 1'b1);
      checkOutput("start_ignored_data", (seen.size() > 0) ? seen[0].data : 64'h0, 64'h0BADC0DECAFEF00D);

      // Reset in the middle of the data phase abandons the load.
      pulseStart();
      for (int i = 0; i < 4; i++) applyStimulus((i == 0) ? 8'h02 : 8'h00, 1'b0);
      for (int i = 0; i < 5; i++) applyStimulus(8'($urandom), 1'b0);
      #2 reset = 1'b1;
      #1 checkResetValues("midrst");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      curWords = '{$urandom, $urandom};
      runLoad(2, 1'b1, 1'b0, "after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
